// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle rvsimple core.
// Decides each cycle which datapath registers load (PC, IR, MDR, ALU-out,
// regfile), drives the memory-bus handshake, detects bus timeouts and counts
// retired instructions. Outputs are combinational from the registered state,
// the current opcode and bus_ready, and are forced low while reset is held.
module multicycle_sequencer #(
  parameter int BUS_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             inst_opcode,
  input  logic                   bus_ready,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write_enable,
  output logic                   mdr_write_enable,
  output logic                   alu_out_write_enable,
  output logic                   regfile_write_enable,
  output logic                   pc_write_enable,
  output logic [2:0]             state,
  output logic                   bus_error,
  output logic                   illegal_instruction,
  output logic [COUNT_WIDTH-1:0] instret
);

  // Wait counter must hold values 0..BUS_TIMEOUT; never narrower than 1 bit.
  localparam int WCW = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [WCW-1:0] WC_LIMIT = WCW'(BUS_TIMEOUT);
  localparam bit TIMEOUT_EN = (BUS_TIMEOUT > 0);

  // Opcode encodings (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [WCW-1:0]         wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] instret_q, instret_d;
  logic                   bus_error_q, bus_error_d;
  logic                   illegal_q, illegal_d;

  // Ungated versions of the outputs; reset masking is applied at the ports.
  logic rd_c, wr_c, ir_c, mdr_c, alu_c, rf_c, pc_c;
  logic req_pending;

  logic is_load, is_store, is_branch, is_nop, is_wb, is_legal;

  // Classify the opcode currently presented from IR.
  always_comb begin
    is_load   = (inst_opcode == OPC_LOAD);
    is_store  = (inst_opcode == OPC_STORE);
    is_branch = (inst_opcode == OPC_BRANCH);
    is_nop    = (inst_opcode == OPC_FENCE) || (inst_opcode == OPC_SYSTEM);
    is_wb     = (inst_opcode == OPC_OP)    || (inst_opcode == OPC_OPIMM) ||
                (inst_opcode == OPC_LUI)   || (inst_opcode == OPC_AUIPC) ||
                (inst_opcode == OPC_JAL)   || (inst_opcode == OPC_JALR);
    is_legal  = is_load || is_store || is_branch || is_nop || is_wb;
  end

  // Next-state, enables, timeout and counter update.
  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    illegal_d   = illegal_q;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    ir_c        = 1'b0;
    mdr_c       = 1'b0;
    alu_c       = 1'b0;
    rf_c        = 1'b0;
    pc_c        = 1'b0;
    req_pending = 1'b0;

    case (state_q)
      S_FETCH: begin
        rd_c        = 1'b1;
        req_pending = 1'b1;
        if (bus_ready) begin
          ir_c    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          illegal_d = 1'b1;
          state_d   = S_ERROR;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_c = 1'b1;
        if (is_load || is_store) begin
          state_d = S_MEMORY;
        end else if (is_branch || is_nop) begin
          pc_c    = 1'b1;
          state_d = S_FETCH;
        end else if (is_wb) begin
          state_d = S_WRITEBACK;
        end else begin
          // Opcode changed under us after DECODE: treat as illegal.
          illegal_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_MEMORY: begin
        if (is_load) begin
          rd_c        = 1'b1;
          req_pending = 1'b1;
          if (bus_ready) begin
            mdr_c   = 1'b1;
            state_d = S_WRITEBACK;
          end
        end else if (is_store) begin
          wr_c        = 1'b1;
          req_pending = 1'b1;
          if (bus_ready) begin
            pc_c    = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          illegal_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        rf_c    = 1'b1;
        pc_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Final wait cycle without bus_ready: abandon the request. bus_ready in
    // that same cycle has already taken the normal path above and wins.
    if (TIMEOUT_EN && req_pending && !bus_ready && (wait_q == WC_LIMIT)) begin
      bus_error_d = 1'b1;
      state_d     = S_ERROR;
    end

    // Wait counter restarts on any state change or completed transfer.
    if ((state_d != state_q) || bus_ready) begin
      wait_d = '0;
    end else if (req_pending) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end

    instret_d = pc_c ? instret_q + 1'b1 : instret_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      instret_q   <= '0;
      bus_error_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      instret_q   <= instret_d;
      bus_error_q <= bus_error_d;
      illegal_q   <= illegal_d;
    end
  end

  // Requests and enables are masked while reset is asserted so that a reset
  // landing mid-instruction can never leak a PC or regfile write.
  assign mem_read             = reset & rd_c;
  assign mem_write            = reset & wr_c;
  assign ir_write_enable      = reset & ir_c;
  assign mdr_write_enable     = reset & mdr_c;
  assign alu_out_write_enable = reset & alu_c;
  assign regfile_write_enable = reset & rf_c;
  assign pc_write_enable      = reset & pc_c;

  assign state               = state_q;
  assign bus_error           = bus_error_q;
  assign illegal_instruction = illegal_q;
  assign instret             = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-cycle expected state/enable vectors are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_multicycle_sequencer;

  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic [6:0]    inst_opcode;
  logic          bus_ready;
  logic          mem_read, mem_write, ir_write_enable, mdr_write_enable;
  logic          alu_out_write_enable, regfile_write_enable, pc_write_enable;
  logic [2:0]    state;
  logic          bus_error, illegal_instruction;
  logic [CW-1:0] instret;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_instret = '0;

  // {state, mem_read, mem_write, ir_we, mdr_we, alu_we, rf_we, pc_we}
  localparam logic [9:0] V_RST   = {3'd0, 7'b0000000};
  localparam logic [9:0] F_NR    = {3'd0, 7'b1000000};
  localparam logic [9:0] F_RDY   = {3'd0, 7'b1010000};
  localparam logic [9:0] DEC     = {3'd1, 7'b0000000};
  localparam logic [9:0] EX_A    = {3'd2, 7'b0000100};
  localparam logic [9:0] EX_P    = {3'd2, 7'b0000101};
  localparam logic [9:0] ML_NR   = {3'd3, 7'b1000000};
  localparam logic [9:0] ML_RDY  = {3'd3, 7'b1001000};
  localparam logic [9:0] MS_NR   = {3'd3, 7'b0100000};
  localparam logic [9:0] MS_RDY  = {3'd3, 7'b0100001};
  localparam logic [9:0] WB      = {3'd4, 7'b0000011};
  localparam logic [9:0] ERR     = {3'd5, 7'b0000000};

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [6:0] op;
    logic [9:0] exp;
  } step_t;

  logic [9:0] sb[$];

  multicycle_sequencer #(.BUS_TIMEOUT(15), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .inst_opcode(inst_opcode), .bus_ready(bus_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write_enable(ir_write_enable),
    .mdr_write_enable(mdr_write_enable), .alu_out_write_enable(alu_out_write_enable),
    .regfile_write_enable(regfile_write_enable), .pc_write_enable(pc_write_enable),
    .state(state), .bus_error(bus_error), .illegal_instruction(illegal_instruction),
    .instret(instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(logic rst, logic rdy, logic [6:0] op, logic [9:0] exp);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.op = op; s.exp = exp;
    return s;
  endfunction

  function automatic logic [9:0] obs();
    return {state, mem_read, mem_write, ir_write_enable, mdr_write_enable,
            alu_out_write_enable, regfile_write_enable, pc_write_enable};
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue its expectation;
  // outputs are sampled 2 time units later, well before the rising edge.
  task automatic drive(input step_t s);
    @(negedge clock);
    reset       = s.rst;
    bus_ready   = s.rdy;
    inst_opcode = s.op;
    sb.push_back(s.exp);
    #2;
  endtask

  task automatic test_reset();
    step_t st[$];
    logic [9:0] e;
    for (int i = 0; i < 3; i++) st.push_back(mk(1'b0, 1'b1, OP_IMM, V_RST));
    st.push_back(mk(1'b1, 1'b0, OP_IMM, F_NR));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL reset[%0d] got=%h exp=%h", i, obs(), e); end
      if (i == 0) begin
        checks++;
        if ({instret, bus_error, illegal_instruction} !== {CW'(0), 2'b00}) begin
          failures++;
          $display("FAIL reset_regs got instret=%0d berr=%b ill=%b exp 0/0/0", instret, bus_error, illegal_instruction);
        end
      end
    end
  endtask

  task automatic test_op_imm();
    step_t st[$];
    logic [9:0] e;
    st = '{mk(1, 1, OP_IMM, F_RDY), mk(1, 1, OP_IMM, DEC), mk(1, 1, OP_IMM, EX_A), mk(1, 1, OP_IMM, WB)};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL op_imm[%0d] got=%h exp=%h", i, obs(), e); end
    end
    exp_instret = exp_instret + 1'b1;
    #4; checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL op_imm_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_load_wait();
    step_t st[$];
    logic [9:0] e;
    st = '{mk(1, 1, OP_LOAD, F_RDY), mk(1, 1, OP_LOAD, DEC), mk(1, 1, OP_LOAD, EX_A),
           mk(1, 0, OP_LOAD, ML_NR), mk(1, 0, OP_LOAD, ML_NR), mk(1, 1, OP_LOAD, ML_RDY),
           mk(1, 1, OP_LOAD, WB)};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL load[%0d] got=%h exp=%h", i, obs(), e); end
    end
    exp_instret = exp_instret + 1'b1;
    #4; checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    logic [9:0] e;
    st = '{mk(1, 1, OP_BR, F_RDY), mk(1, 1, OP_BR, DEC), mk(1, 1, OP_BR, EX_P),
           mk(1, 1, OP_ST, F_RDY), mk(1, 1, OP_ST, DEC), mk(1, 1, OP_ST, EX_A),
           mk(1, 0, OP_ST, MS_NR), mk(1, 1, OP_ST, MS_RDY)};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL b2b[%0d] got=%h exp=%h", i, obs(), e); end
    end
    exp_instret = exp_instret + 2'd2;
    #4; checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  // bus_ready arriving on the last allowed wait cycle completes normally.
  task automatic test_ready_last();
    step_t st[$];
    logic [9:0] e;
    for (int i = 0; i < 15; i++) st.push_back(mk(1, 0, OP_BR, F_NR));
    st.push_back(mk(1, 1, OP_BR, F_RDY));
    st.push_back(mk(1, 1, OP_BR, DEC));
    st.push_back(mk(1, 1, OP_BR, EX_P));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL ready_last[%0d] got=%h exp=%h", i, obs(), e); end
    end
    exp_instret = exp_instret + 1'b1;
    #4; checks++;
    if ({instret, bus_error} !== {exp_instret, 1'b0}) begin
      failures++; $display("FAIL ready_last_regs got instret=%0d berr=%b exp %0d/0", instret, bus_error, exp_instret);
    end
  endtask

  // Enough branches to roll the narrow instret counter over.
  task automatic test_wrap();
    step_t st[$];
    logic [9:0] e;
    for (int n = 0; n < 17; n++) begin
      st.push_back(mk(1, 1, OP_BR, F_RDY));
      st.push_back(mk(1, 1, OP_BR, DEC));
      st.push_back(mk(1, 1, OP_BR, EX_P));
    end
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL wrap[%0d] got=%h exp=%h", i, obs(), e); end
    end
    exp_instret = exp_instret + 5'd17;
    #4; checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL wrap_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_timeout();
    step_t st[$];
    logic [9:0] e;
    for (int i = 0; i < 16; i++) st.push_back(mk(1, 0, OP_IMM, F_NR));
    st.push_back(mk(1, 1, OP_IMM, ERR));
    st.push_back(mk(1, 0, OP_IMM, ERR));
    st.push_back(mk(1, 1, OP_IMM, ERR));
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs(), e); end
    end
    checks++;
    if ({bus_error, illegal_instruction, instret} !== {2'b10, exp_instret}) begin
      failures++;
      $display("FAIL timeout_flags got berr=%b ill=%b instret=%0d exp 1/0/%0d", bus_error, illegal_instruction, instret, exp_instret);
    end
  endtask

  task automatic test_illegal();
    step_t st[$];
    logic [9:0] e;
    st = '{mk(0, 1, OP_BAD, V_RST), mk(1, 1, OP_BAD, F_RDY), mk(1, 1, OP_BAD, DEC),
           mk(1, 1, OP_BAD, ERR), mk(1, 0, OP_BAD, ERR), mk(1, 1, OP_BAD, ERR), mk(1, 1, OP_BAD, ERR)};
    exp_instret = '0;
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL illegal[%0d] got=%h exp=%h", i, obs(), e); end
      if (i == 0) begin
        checks++;
        if ({bus_error, illegal_instruction, instret} !== {2'b00, CW'(0)}) begin
          failures++; $display("FAIL illegal_reset_clr got berr=%b ill=%b instret=%0d exp 0/0/0", bus_error, illegal_instruction, instret);
        end
      end
    end
    checks++;
    if ({illegal_instruction, bus_error, instret} !== {2'b10, CW'(0)}) begin
      failures++; $display("FAIL illegal_flags got ill=%b berr=%b instret=%0d exp 1/0/0", illegal_instruction, bus_error, instret);
    end
  endtask

  // Reset landing in WRITEBACK must suppress the regfile and PC writes.
  task automatic test_reset_mid();
    step_t st[$];
    logic [9:0] e;
    st = '{mk(0, 1, OP_IMM, V_RST), mk(1, 1, OP_IMM, F_RDY), mk(1, 1, OP_IMM, DEC),
           mk(1, 1, OP_IMM, EX_A), mk(0, 1, OP_IMM, V_RST), mk(1, 0, OP_IMM, F_NR)};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL reset_mid[%0d] got=%h exp=%h", i, obs(), e); end
    end
    checks++;
    if ({instret, illegal_instruction} !== {CW'(0), 1'b0}) begin
      failures++; $display("FAIL reset_mid_regs got instret=%0d ill=%b exp 0/0", instret, illegal_instruction);
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus_ready   = 1'b1;
    inst_opcode = OP_IMM;
    test_reset();
    test_op_imm();
    test_load_wait();
    test_back_to_back();
    test_ready_last();
    test_wrap();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
